// File: rtl/pipe_game_pkg.sv
// Shared constants, state encoding and LFSR helper for the pipe game logic.
package pipe_game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam int SPEED      = 2;
  localparam int SPACING    = 220;
  localparam int SPAWN_X    = 680;
  localparam int GAP        = 120;
  localparam int GAP_RESET  = 160;
  localparam int GAP_BASE   = 40;
  localparam int PIPE_W     = 52;
  localparam int PIPE_H     = 320;
  localparam int BIRD_X     = 550;
  localparam int BIRD_W     = 34;
  localparam int BIRD_H     = 24;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // XNOR feedback: all-ones is the lockup state, so the A5 seed is safe.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ~^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Control inputs and per-pipe render outputs between game logic and drawing controller.
interface pipe_scroller_if;
  logic       frameTick;
  logic       start;
  logic [9:0] birdY;

  logic [9:0] PIPEUP1X, PIPEUP1Y, PIPEUP1SKIPY, PIPEDOWN1X, PIPEDOWN1Y;
  logic       PIPEUP1VISIBLE, PIPEDOWN1VISIBLE;
  logic [9:0] PIPEUP2X, PIPEUP2Y, PIPEUP2SKIPY, PIPEDOWN2X, PIPEDOWN2Y;
  logic       PIPEUP2VISIBLE, PIPEDOWN2VISIBLE;
  logic [9:0] PIPEUP3X, PIPEUP3Y, PIPEUP3SKIPY, PIPEDOWN3X, PIPEDOWN3Y;
  logic       PIPEUP3VISIBLE, PIPEDOWN3VISIBLE;

  logic [9:0] score;
  logic       gameOver;
  logic       running;

  modport master (
    output frameTick, start, birdY,
    input  PIPEUP1X, PIPEUP1Y, PIPEUP1SKIPY, PIPEUP1VISIBLE, PIPEDOWN1X, PIPEDOWN1Y, PIPEDOWN1VISIBLE,
    input  PIPEUP2X, PIPEUP2Y, PIPEUP2SKIPY, PIPEUP2VISIBLE, PIPEDOWN2X, PIPEDOWN2Y, PIPEDOWN2VISIBLE,
    input  PIPEUP3X, PIPEUP3Y, PIPEUP3SKIPY, PIPEUP3VISIBLE, PIPEDOWN3X, PIPEDOWN3Y, PIPEDOWN3VISIBLE,
    input  score, gameOver, running
  );

  modport slave (
    input  frameTick, start, birdY,
    output PIPEUP1X, PIPEUP1Y, PIPEUP1SKIPY, PIPEUP1VISIBLE, PIPEDOWN1X, PIPEDOWN1Y, PIPEDOWN1VISIBLE,
    output PIPEUP2X, PIPEUP2Y, PIPEUP2SKIPY, PIPEUP2VISIBLE, PIPEDOWN2X, PIPEDOWN2Y, PIPEDOWN2VISIBLE,
    output PIPEUP3X, PIPEUP3Y, PIPEUP3SKIPY, PIPEUP3VISIBLE, PIPEDOWN3X, PIPEDOWN3Y, PIPEDOWN3VISIBLE,
    output score, gameOver, running
  );
endinterface

// File: rtl/pipe_lane.sv
// One pipe pair: X position and gap top, with wrap, score-pass and bird-hit detection.
module pipe_lane
  import pipe_game_pkg::*;
#(
  parameter logic [10:0] RESET_X = 11'd680
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        reload_i,
  input  logic [3:0]  speed_i,
  input  logic [9:0]  wrap_gap_i,
  input  logic [9:0]  bird_y_i,
  output logic [10:0] x_o,
  output logic [9:0]  gap_top_o,
  output logic        wrap_o,
  output logic        pass_o,
  output logic        hit_o
);

  localparam logic [11:0] PASS_X   = 12'(BIRD_X - PIPE_W);
  localparam logic [11:0] HIT_X_HI = 12'(BIRD_X + BIRD_W);
  localparam logic [11:0] RING     = 12'(3 * SPACING);
  localparam logic [9:0]  GAP_RST  = 10'(GAP_RESET);
  localparam logic [10:0] GAP_H    = 11'(GAP);
  localparam logic [10:0] BIRD_HH  = 11'(BIRD_H);

  logic [10:0] x_q, x_d;
  logic [9:0]  gap_q, gap_d;
  logic [11:0] x_ext, spd_ext, x_next;
  logic [10:0] bird_bot, gap_bot;

  always_comb begin
    x_ext    = {1'b0, x_q};
    spd_ext  = {8'b0, speed_i};
    wrap_o   = x_ext < spd_ext;
    x_next   = wrap_o ? (x_ext + RING - spd_ext) : (x_ext - spd_ext);
    // Right edge x+PIPE_W moves from >= BIRD_X to < BIRD_X on this tick.
    pass_o   = (x_ext >= PASS_X) && (x_next < PASS_X);
    bird_bot = {1'b0, bird_y_i} + BIRD_HH;
    gap_bot  = {1'b0, gap_q} + GAP_H;
    hit_o    = (x_ext < HIT_X_HI) && (x_ext > PASS_X) &&
               ((bird_y_i < gap_q) || (bird_bot > gap_bot));
  end

  always_comb begin
    x_d   = x_q;
    gap_d = gap_q;
    if (reload_i) begin
      x_d   = RESET_X;
      gap_d = GAP_RST;
    end else if (tick_i) begin
      x_d = x_next[10:0];
      if (wrap_o) gap_d = wrap_gap_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= RESET_X;
      gap_q <= GAP_RST;
    end else begin
      x_q   <= x_d;
      gap_q <= gap_d;
    end
  end

  assign x_o       = x_q;
  assign gap_top_o = gap_q;

endmodule

// File: rtl/pipe_scroller.sv
// Pipe game logic: scrolls three pipe lanes, runs IDLE/RUN/OVER, LFSR gaps and score.
// Optional PIPE_SPEEDUP_EN raises scroll speed with score (up to +4 px/frame).
module pipe_scroller
  import pipe_game_pkg::*;
(
  input  logic           CLOCK,
  input  logic           reset,
  pipe_scroller_if.slave bus
);

  localparam logic [10:0] VIS_LIMIT = 11'(SCREEN_W);
  localparam logic [9:0]  GAP_H     = 10'(GAP);
  localparam logic [9:0]  SPRITE_H  = 10'(PIPE_H);
  localparam logic [9:0]  GAP_LO    = 10'(GAP_BASE);
  localparam logic [10:0] SCORE_MAX = 11'd999;

  game_state_e state_q;
  logic        running_q, over_q;
  logic [9:0]  score_q, score_d;
  logic [7:0]  lfsr_q, lf1, lf2, lfsr_d;
  logic [3:0]  speed;
  logic        hit_any, advance, reload;
  logic [1:0]  pass_cnt;
  logic [10:0] score_sum;

  logic [10:0] x    [3];
  logic [9:0]  gap  [3];
  logic [9:0]  gin  [3];
  logic        wrap [3];
  logic        pass [3];
  logic        hit  [3];

`ifdef PIPE_SPEEDUP_EN
  assign speed = 4'(SPEED) + ((score_q[9:3] > 7'd4) ? 4'd4 : {1'b0, score_q[5:3]});
`else
  assign speed = 4'(SPEED);
`endif

  // Wrapping lanes each take one LFSR step, chained in pipe index order.
  always_comb begin
    gin[0] = GAP_LO + {2'b00, lfsr_q[6:0], 1'b0};
    lf1    = wrap[0] ? lfsr_step(lfsr_q) : lfsr_q;
    gin[1] = GAP_LO + {2'b00, lf1[6:0], 1'b0};
    lf2    = wrap[1] ? lfsr_step(lf1) : lf1;
    gin[2] = GAP_LO + {2'b00, lf2[6:0], 1'b0};
    lfsr_d = wrap[2] ? lfsr_step(lf2) : lf2;
  end

  always_comb begin
    hit_any   = (state_q == ST_RUN) && (hit[0] || hit[1] || hit[2]);
    advance   = (state_q == ST_RUN) && bus.frameTick && !hit_any;
    reload    = (state_q == ST_OVER) && bus.start;
    pass_cnt  = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
    score_sum = {1'b0, score_q} + {9'b0, pass_cnt};
    score_d   = (score_sum > SCORE_MAX) ? SCORE_MAX[9:0] : score_sum[9:0];
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    pipe_lane #(
      .RESET_X(11'(SPAWN_X + i * SPACING))
    ) u_lane (
      .clk_i     (CLOCK),
      .rst_ni    (reset),
      .tick_i    (advance),
      .reload_i  (reload),
      .speed_i   (speed),
      .wrap_gap_i(gin[i]),
      .bird_y_i  (bus.birdY),
      .x_o       (x[i]),
      .gap_top_o (gap[i]),
      .wrap_o    (wrap[i]),
      .pass_o    (pass[i]),
      .hit_o     (hit[i])
    );
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      over_q    <= 1'b0;
      score_q   <= '0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
        ST_RUN: begin
          // A hit wins over a same-cycle frame tick; that tick is dropped.
          if (hit_any) begin
            state_q   <= ST_OVER;
            running_q <= 1'b0;
            over_q    <= 1'b1;
          end else if (bus.frameTick) begin
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
          end
        end
        ST_OVER: if (bus.start) begin
          state_q <= ST_IDLE;
          over_q  <= 1'b0;
          score_q <= '0;
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          over_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PIPEUP1X         = x[0][9:0];
  assign bus.PIPEUP1Y         = '0;
  assign bus.PIPEUP1SKIPY     = SPRITE_H - gap[0];
  assign bus.PIPEUP1VISIBLE   = x[0] < VIS_LIMIT;
  assign bus.PIPEDOWN1X       = x[0][9:0];
  assign bus.PIPEDOWN1Y       = gap[0] + GAP_H;
  assign bus.PIPEDOWN1VISIBLE = x[0] < VIS_LIMIT;

  assign bus.PIPEUP2X         = x[1][9:0];
  assign bus.PIPEUP2Y         = '0;
  assign bus.PIPEUP2SKIPY     = SPRITE_H - gap[1];
  assign bus.PIPEUP2VISIBLE   = x[1] < VIS_LIMIT;
  assign bus.PIPEDOWN2X       = x[1][9:0];
  assign bus.PIPEDOWN2Y       = gap[1] + GAP_H;
  assign bus.PIPEDOWN2VISIBLE = x[1] < VIS_LIMIT;

  assign bus.PIPEUP3X         = x[2][9:0];
  assign bus.PIPEUP3Y         = '0;
  assign bus.PIPEUP3SKIPY     = SPRITE_H - gap[2];
  assign bus.PIPEUP3VISIBLE   = x[2] < VIS_LIMIT;
  assign bus.PIPEDOWN3X       = x[2][9:0];
  assign bus.PIPEDOWN3Y       = gap[2] + GAP_H;
  assign bus.PIPEDOWN3VISIBLE = x[2] < VIS_LIMIT;

  assign bus.score    = score_q;
  assign bus.gameOver = over_q;
  assign bus.running  = running_q;

endmodule
